// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus between a host and bin_to_bcd_seq.
// The master drives the operand and start; the slave returns status and the packed BCD result.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
);
  logic [BIN_W-1:0]    bin_in;
  logic                start;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic                ovf;

  modport master (output bin_in, output start,
                  input busy, input done, input bcd_out, input ovf);
  modport slave  (input bin_in, input start,
                  output busy, output done, output bcd_out, output ovf);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BCD_SATURATE_EN to make out-of-range inputs produce all nines instead of the value mod 10^DIGITS.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  bin_to_bcd_seq_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start; bcd_out/ovf hold the last result
  // SHIFT | add-3 then shift one bit per clock; cnt_q bits remain

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0]      MAX_VAL = pow10_m1(DIGITS);
  localparam logic [BCD_W-1:0] NINES   = {DIGITS{4'h9}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;

    // All digits are corrected in parallel before the shift.
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj[BCD_W-2:0], shift_q[BIN_W-1]};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d   = bus.bin_in;
          scratch_d = '0;
          cnt_d     = CNT_W'(BIN_W);
          pend_d    = (64'(bus.bin_in) > MAX_VAL);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        shift_d   = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
`ifdef BCD_SATURATE_EN
          bcd_d = pend_q ? NINES : shifted;
`else
          bcd_d = shifted;
`endif
          ovf_d   = pend_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed table, random vectors against an arithmetic model, and handshake corners.
// Honours BCD_SATURATE_EN the same way as the design.
module tb_bin_to_bcd_seq;
  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [26:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Decimal digits obtained by plain division, not by shift-add.
  function automatic logic [31:0] model_bcd(input longint unsigned v);
    longint unsigned r;
    logic [31:0] res;
`ifdef BCD_SATURATE_EN
    if (v > 64'd99999999) return 32'h99999999;
`endif
    r = v % 64'd100000000;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  // One conversion from IDLE; checks latency, busy, single-cycle done and output hold.
  task automatic run_conv(input logic [26:0] v, output logic [31:0] b, output logic o);
    int lat;
    logic [31:0] prev;
    logic changed;
    @(negedge clock);
    bus.bin_in = v;
    bus.start  = 1'b1;
    prev = bus.bcd_out;
    changed = 1'b0;
    @(posedge clock); #1;
    bus.start = 1'b0;
    chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
    lat = 0;
    while (!bus.done && lat < 100) begin
      if (bus.bcd_out !== prev) changed = 1'b1;
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd27);
    chk("hold_during_conv", {63'd0, changed}, 64'd0);
    chk("busy_at_done", {63'd0, bus.busy}, 64'd0);
    b = bus.bcd_out;
    o = bus.ovf;
    @(posedge clock); #1;
    chk("done_one_cycle", {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    logic [31:0] b;
    logic        o;
    logic [26:0] r;
    int          ndone;
    int          k1, k2;
    logic [31:0] b1, b2;

    checks = 0;
    errors = 0;

    vecs[0] = '{27'd12345678,  32'h12345678, 1'b0};
    vecs[1] = '{27'd0,         32'h00000000, 1'b0};
    vecs[2] = '{27'd99999999,  32'h99999999, 1'b0};
    vecs[3] = '{27'd1,         32'h00000001, 1'b0};
    vecs[4] = '{27'd90909090,  32'h90909090, 1'b0};
    vecs[5] = '{27'd5555555,   32'h05555555, 1'b0};
    vecs[6] = '{27'd10000000,  32'h10000000, 1'b0};
    vecs[7] = '{27'd99999998,  32'h99999998, 1'b0};
`ifdef BCD_SATURATE_EN
    vecs[8] = '{27'd100000000, 32'h99999999, 1'b1};
    vecs[9] = '{27'd134217727, 32'h99999999, 1'b1};
`else
    vecs[8] = '{27'd100000000, 32'h00000000, 1'b1};
    vecs[9] = '{27'd134217727, 32'h34217727, 1'b1};
`endif

    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_bcd",  64'(bus.bcd_out), 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_ovf",  {63'd0, bus.ovf},  64'd0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst2_bcd",  64'(bus.bcd_out), 64'd0);
    chk("rst2_busy", {63'd0, bus.busy}, 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].bin, b, o);
      chk($sformatf("vec%0d_bcd", i), 64'(b), 64'(vecs[i].bcd));
      chk($sformatf("vec%0d_ovf", i), {63'd0, o}, {63'd0, vecs[i].ovf});
    end

    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0:       r = 27'($urandom_range(0, 134217727));
        1:       r = 27'($urandom_range(0, 99999999));
        default: r = 27'($urandom_range(0, 9999));
      endcase
      run_conv(r, b, o);
      chk($sformatf("rand%0d_bcd", i), 64'(b), 64'(model_bcd(64'(r))));
      chk($sformatf("rand%0d_ovf", i), {63'd0, o}, {63'd0, (r > 27'd99999999)});
    end

    // Start while busy is ignored; start held across done is accepted on the next edge.
    @(negedge clock);
    bus.bin_in = 27'd42;
    bus.start  = 1'b1;
    @(posedge clock); #1;
    ndone = 0; k1 = -1; k2 = -1; b1 = '0; b2 = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      bus.start = (k == 10) || (k >= 26 && k <= 29);
      if (k >= 10) bus.bin_in = (k == 12) ? 27'd3 : 27'd7;
      @(posedge clock); #1;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin k1 = k; b1 = bus.bcd_out; end
        if (ndone == 2) begin k2 = k; b2 = bus.bcd_out; end
      end
    end
    chk("busy_start_dones", 64'(ndone), 64'd2);
    chk("first_done_edge",  64'(k1), 64'd27);
    chk("first_done_bcd",   64'(b1), 64'h42);
    chk("second_done_edge", 64'(k2), 64'd55);
    chk("second_done_bcd",  64'(b2), 64'h7);

    // Reset mid-conversion abandons the result.
    @(negedge clock);
    bus.bin_in = 27'd555;
    bus.start  = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      reset_n = !(k == 15 || k == 16);
      @(posedge clock); #1;
      if (bus.done) ndone++;
    end
    chk("rst_mid_no_done", 64'(ndone), 64'd0);
    chk("rst_mid_bcd",     64'(bus.bcd_out), 64'd0);
    chk("rst_mid_busy",    {63'd0, bus.busy}, 64'd0);
    run_conv(27'd555, b, o);
    chk("after_rst_bcd", 64'(b), 64'h555);
    chk("after_rst_ovf", {63'd0, o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one bit per clock.
- Sits directly upstream of the 8-digit seven-segment scan multiplexer.
- Its 32-bit packed BCD output drives the multiplexer's 32-bit number input, so the display shows decimal instead of hex.
- Start/busy/done handshake. The output register holds the last result steady while the next conversion runs.

Parameters:
- BIN_W, 27: width of the binary input. 27 bits covers 0..99,999,999 plus an overflow margin.
- DIGITS, 8: number of BCD digits. Output width is 4*DIGITS.

Ports:
- clock, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- bin_in, input, BIN_W: binary value to convert. Sampled only on an accepted start.
- start, input, 1: request conversion. Accepted only in IDLE.
- busy, output, 1: high while a conversion is in progress.
- done, output, 1: single-cycle pulse; bcd_out was updated on the same edge.
- bcd_out, output, 4*DIGITS: packed BCD result; digit 0 is in [3:0].
- ovf, output, 1: last accepted bin_in exceeded 10^DIGITS-1. Valid with done and held until the next done.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE, busy=0, done=0, bcd_out=0, ovf=0.
  - Shift register, scratch BCD register and bit counter cleared.
  - Any conversion in flight is abandoned and no done is issued.
- States: IDLE, SHIFT.
- IDLE, start=1 at an edge:
  - capture bin_in into the shift register;
  - clear scratch BCD;
  - counter=BIN_W;
  - latch the overflow compare (bin_in > 10^DIGITS-1) into a pending flag;
  - busy<=1; next state SHIFT.
- IDLE, start=0: hold. done<=0.
- SHIFT, each edge:
  - every scratch digit >=5 gets +3, evaluated on all digits in parallel;
  - then shift {scratch, shiftreg} left by one bit;
  - the bit shifted out of the top digit is discarded;
  - counter decrements.
- SHIFT, last shift (counter==1 at the edge):
  - bcd_out<=post-shift scratch value, or the saturated value, see Optional Feature;
  - ovf<=pending flag; done<=1; busy<=0; next state IDLE.
- Latency: start accepted at edge E0. busy is high after E0. done is high and bcd_out valid after edge E0+BIN_W (27 cycles). done lasts exactly one cycle.
- start while busy is ignored: no restart and no queueing. bin_in changes during SHIFT have no effect.
- start high in the cycle where done=1 (state already IDLE) is accepted. Back-to-back throughput is one result per BIN_W+1 cycles.
- bcd_out changes only on the done edge or on reset. It never shows partial results.
- Each digit of bcd_out is 0..9 for every input.
- Overflow, macro off: bcd_out = bin_in mod 10^DIGITS, the natural result of dropping top carries. ovf=1.

Optional Feature:
- Macro BCD_SATURATE_EN.
- Defined: when the pending overflow flag is set, the done edge loads bcd_out with all nines (0x99999999 for DIGITS=8) instead of the scratch value. ovf=1.
- Undefined: no saturation. bcd_out = bin_in mod 10^DIGITS. ovf is still reported.
- In-range inputs behave identically in both builds.

Test Plan:
- Reset with no start: bcd_out=0x00000000, busy=0, done=0, ovf=0. Pulse reset_n low mid-output and the values stay 0.
- bin_in=12345678, start one cycle: busy high next cycle. done pulses exactly 27 cycles after the start edge with bcd_out=0x12345678, ovf=0. busy low on that same edge.
- bin_in=0, then 99999999: bcd_out=0x00000000, then 0x99999999. ovf=0 both times.
- bin_in=100000000:
  - macro off: bcd_out=0x00000000, ovf=1;
  - macro on: bcd_out=0x99999999, ovf=1;
  - bin_in=134217727, macro off: bcd_out=0x34217727, ovf=1.
- During a conversion of 42: assert start with bin_in=7 at cycle 10 and change bin_in at cycle 12. The result is 0x00000042 with exactly one done pulse. Then hold start high across the done cycle with bin_in=7: a second done arrives 27 cycles later with 0x00000007.
- Start 555, then reset_n low at cycle 15 and release: no done. bcd_out=0x00000000, busy=0. The next start with 555 yields 0x00000555.
